// File: rtl/v2_trap_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : v2_trap_filter
// Brief    : Streaming trapezoidal shaper with pole-zero correction
//            (d/p/r/s recursion), saturated output.
// Revision : 1.0 - initial release
// ============================================================================
module v2_trap_filter #(
    parameter int ADC_W     = 14,
    parameter int OUT_W     = 16,
    parameter int MAX_DEPTH = 64,
    parameter int ACC_W     = 32,
    parameter int K_DEF     = 8,
    parameter int L_DEF     = 5,
    parameter int M_DEF     = 16,
    parameter int SH_DEF    = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [ADC_W-1:0]              input_data,
    output logic                          in_ready,
    input  logic [$clog2(MAX_DEPTH)-1:0]  cfg_k,
    input  logic [$clog2(MAX_DEPTH)-1:0]  cfg_l,
    input  logic [7:0]                    cfg_m,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cfg_load,
    output logic                          out_valid,
    output logic signed [OUT_W-1:0]       output_data,
    output logic                          sat_flag,
    output logic                          cfg_err
);

    localparam int c_AW = $clog2(MAX_DEPTH);
    localparam logic [c_AW:0] c_SUM_MAX = (c_AW+1)'(MAX_DEPTH - 1);
    localparam logic signed [ACC_W-1:0] c_OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    function automatic logic signed [ACC_W-1:0] f_ext(input logic [ADC_W-1:0] v);
        return {{(ACC_W-ADC_W){1'b0}}, v};
    endfunction

    state_t                   r_state;
    logic [ADC_W-1:0]         r_ring [MAX_DEPTH];
    logic [c_AW-1:0]          r_wp;
    logic [c_AW-1:0]          r_flush_cnt;
    logic [c_AW:0]            r_fill_cnt;
    logic [c_AW-1:0]          r_k;
    logic [c_AW-1:0]          r_l;
    logic [7:0]               r_m;
    logic [4:0]               r_sh;

    logic                     r1_acc, r1_emit;
    logic [ADC_W-1:0]         r1_v, r1_vk, r1_vl, r1_vkl;
    logic                     r2_acc, r2_emit;
    logic signed [ACC_W-1:0]  r2_d;
    logic                     r3_acc, r3_emit;
    logic signed [ACC_W-1:0]  r3_d;
    logic signed [ACC_W-1:0]  r_p;
    logic signed [ACC_W-1:0]  r_s;

    logic [c_AW:0]            w_cfg_sum;
    logic                     w_cfg_legal;
    logic                     w_load_ok;
    logic                     w_accept;
    logic [c_AW:0]            w_kl;
    logic [c_AW-1:0]          w_idx_k, w_idx_l, w_idx_kl;
    logic signed [ACC_W-1:0]  w_d;
    logic signed [ACC_W-1:0]  w_m_ext;
    logic signed [ACC_W-1:0]  w_md;
    logic signed [ACC_W-1:0]  w_s_next;
    logic signed [ACC_W-1:0]  w_y;
    logic                     w_sat_hi, w_sat_lo;

    assign w_cfg_sum   = {1'b0, cfg_k} + {1'b0, cfg_l};
    assign w_cfg_legal = (cfg_k != '0) && (cfg_l != '0) && (w_cfg_sum <= c_SUM_MAX);
    assign w_load_ok   = cfg_load && w_cfg_legal;
    assign in_ready    = (r_state != S_FLUSH);
    // A legal load in the same cycle discards the sample.
    assign w_accept    = in_valid && in_ready && !w_load_ok;

    assign w_kl     = {1'b0, r_k} + {1'b0, r_l};
    assign w_idx_k  = r_wp - r_k;
    assign w_idx_l  = r_wp - r_l;
    assign w_idx_kl = r_wp - w_kl[c_AW-1:0];

    assign w_d      = f_ext(r1_v) - f_ext(r1_vk) - f_ext(r1_vl) + f_ext(r1_vkl);
    assign w_m_ext  = {{(ACC_W-8){1'b0}}, r_m};
    assign w_md     = w_m_ext * r3_d;
    assign w_s_next = r_s + r_p + w_md;
    assign w_y      = w_s_next >>> r_sh;
    assign w_sat_hi = (w_y > c_OUT_MAX);
    assign w_sat_lo = (w_y < c_OUT_MIN);

    // Ring storage carries no reset; FLUSH clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_FLUSH) begin
            r_ring[r_flush_cnt] <= '0;
        end else if (w_accept) begin
            r_ring[r_wp] <= input_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FLUSH;
            r_wp        <= '0;
            r_flush_cnt <= '0;
            r_fill_cnt  <= '0;
            r_k         <= c_AW'(K_DEF);
            r_l         <= c_AW'(L_DEF);
            r_m         <= 8'(M_DEF);
            r_sh        <= 5'(SH_DEF);
            r1_acc      <= 1'b0;
            r1_emit     <= 1'b0;
            r1_v        <= '0;
            r1_vk       <= '0;
            r1_vl       <= '0;
            r1_vkl      <= '0;
            r2_acc      <= 1'b0;
            r2_emit     <= 1'b0;
            r2_d        <= '0;
            r3_acc      <= 1'b0;
            r3_emit     <= 1'b0;
            r3_d        <= '0;
            r_p         <= '0;
            r_s         <= '0;
            out_valid   <= 1'b0;
            output_data <= '0;
            sat_flag    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            r1_acc  <= w_accept;
            r1_emit <= w_accept && (r_state == S_RUN);
            r1_v    <= input_data;
            r1_vk   <= r_ring[w_idx_k];
            r1_vl   <= r_ring[w_idx_l];
            r1_vkl  <= r_ring[w_idx_kl];

            r2_acc  <= r1_acc;
            r2_emit <= r1_emit;
            r2_d    <= w_d;

            r3_acc  <= r2_acc;
            r3_emit <= r2_emit;
            r3_d    <= r2_d;
            if (r2_acc) begin
                r_p <= r_p + r2_d;
            end
            if (r3_acc) begin
                r_s <= w_s_next;
            end

            out_valid <= r3_emit;
            sat_flag  <= r3_emit && (w_sat_hi || w_sat_lo);
            if (r3_emit) begin
                if (w_sat_hi) begin
                    output_data <= c_OUT_MAX[OUT_W-1:0];
                end else if (w_sat_lo) begin
                    output_data <= c_OUT_MIN[OUT_W-1:0];
                end else begin
                    output_data <= w_y[OUT_W-1:0];
                end
            end

            if (w_load_ok) begin
                r_k         <= cfg_k;
                r_l         <= cfg_l;
                r_m         <= cfg_m;
                r_sh        <= cfg_shift;
                cfg_err     <= 1'b0;
                r_state     <= S_FLUSH;
                r_flush_cnt <= '0;
                r_fill_cnt  <= '0;
                r_wp        <= '0;
                r1_acc      <= 1'b0;
                r1_emit     <= 1'b0;
                r2_acc      <= 1'b0;
                r2_emit     <= 1'b0;
                r3_acc      <= 1'b0;
                r3_emit     <= 1'b0;
                out_valid   <= 1'b0;
                sat_flag    <= 1'b0;
                r_p         <= '0;
                r_s         <= '0;
            end else begin
                if (cfg_load) begin
                    cfg_err <= 1'b1;
                end
                case (r_state)
                    S_FLUSH: begin
                        r_p         <= '0;
                        r_s         <= '0;
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                        if (r_flush_cnt == c_AW'(MAX_DEPTH - 1)) begin
                            r_state <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (w_accept) begin
                            r_wp       <= r_wp + 1'b1;
                            r_fill_cnt <= r_fill_cnt + 1'b1;
                            if (r_fill_cnt == w_kl - (c_AW+1)'(1)) begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (w_accept) begin
                            r_wp <= r_wp + 1'b1;
                        end
                    end
                    default: r_state <= S_FLUSH;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_v2_trap_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_v2_trap_filter
// Brief    : Scoreboard bench for v2_trap_filter against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_v2_trap_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [13:0] input_data;
    logic        in_ready;
    logic [5:0]  cfg_k, cfg_l;
    logic [7:0]  cfg_m;
    logic [4:0]  cfg_shift;
    logic        cfg_load;
    logic        out_valid;
    logic [15:0] output_data;
    logic        sat_flag;
    logic        cfg_err;

    v2_trap_filter u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .input_data  (input_data),
        .in_ready    (in_ready),
        .cfg_k       (cfg_k),
        .cfg_l       (cfg_l),
        .cfg_m       (cfg_m),
        .cfg_shift   (cfg_shift),
        .cfg_load    (cfg_load),
        .out_valid   (out_valid),
        .output_data (output_data),
        .sat_flag    (sat_flag),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          c;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    int   mk, ml, mm, msh, mn;
    int   mp, ms;
    int   hv[2048];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset(input int k, input int l, input int m, input int sh);
        mk = k; ml = l; mm = m; msh = sh;
        mn = 0; mp = 0; ms = 0;
        q.delete();
    endtask

    function automatic int tap(input int x);
        return (mn - x >= 0) ? hv[mn - x] : 0;
    endfunction

    task automatic model_accept(input int v);
        int   d, r, y;
        exp_t e;
        d = v - tap(mk) - tap(ml) + tap(mk + ml);
        hv[mn] = v;
        mp = mp + d;
        r  = mp + mm * d;
        ms = ms + r;
        y  = ms >>> msh;
        if (y > 32767) begin
            e.d = 16'h7FFF; e.s = 1'b1;
        end else if (y < -32768) begin
            e.d = 16'h8000; e.s = 1'b1;
        end else begin
            e.d = y[15:0];  e.s = 1'b0;
        end
        e.c = cyc + 4;
        if (mn >= mk + ml) q.push_back(e);
        mn++;
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("output_data", $signed(output_data), $signed(e.d));
                chk("sat_flag", sat_flag, e.s);
                chk("latency_cycle", cyc, e.c);
            end
        end
    end

    task automatic send(input int v, input bit vld);
        in_valid   = vld;
        input_data = v[13:0];
        if (vld) model_accept(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_flush();
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 200) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("flush_len", cnt, 64);
    endtask

    task automatic load(input int k, input int l, input int m, input int sh);
        bit legal;
        legal     = (k >= 1) && (l >= 1) && (k + l <= 63);
        cfg_k     = k[5:0];
        cfg_l     = l[5:0];
        cfg_m     = m[7:0];
        cfg_shift = sh[4:0];
        cfg_load  = 1'b1;
        @(posedge clk); #1;
        cfg_load  = 1'b0;
        chk("cfg_err", cfg_err, !legal);
        if (legal) begin
            model_reset(k, l, m, sh);
            wait_flush();
        end
    endtask

    task automatic drain_check();
        idle(8);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; input_data = '0;
        cfg_k = '0; cfg_l = '0; cfg_m = '0; cfg_shift = '0; cfg_load = 1'b0;
        model_reset(8, 5, 16, 7);
        idle(3);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_output_data", output_data, 0);
        chk("rst_cfg_err", cfg_err, 0);
        reset = 1'b1;
        // Samples offered during the flush window must be ignored.
        in_valid = 1'b1; input_data = 14'd1234;
        wait_flush();
        in_valid = 1'b0;
        idle(6);
        chk("queue_empty_after_flush", q.size(), 0);

        // Default configuration with random data.
        for (int i = 0; i < 13; i++) send(0, 1);
        for (int i = 0; i < 24; i++) send($urandom_range(16383), 1);
        drain_check();

        // Step response, continuous.
        load(8, 5, 0, 0);
        for (int i = 0; i < 13; i++) send(0, 1);
        for (int i = 0; i < 20; i++) send(100, 1);
        drain_check();

        // Step response with gaps.
        load(8, 5, 0, 0);
        for (int i = 0; i < 13; i++) begin send(0, 1); send(0, 0); end
        for (int i = 0; i < 20; i++) begin send(100, 1); send(777, 0); end
        drain_check();

        // Illegal loads keep the current configuration running.
        load(0, 5, 3, 2);
        for (int i = 0; i < 15; i++) send(0, 1);
        load(32, 32, 3, 2);
        chk("cfg_err_sticky", cfg_err, 1);
        for (int i = 0; i < 20; i++) send(100, 1);
        drain_check();

        // Long taps: positive and negative saturation.
        load(31, 31, 0, 0);
        chk("cfg_err_cleared", cfg_err, 0);
        for (int i = 0; i < 62; i++) send(0, 1);
        for (int i = 0; i < 70; i++) send(16383, 1);
        for (int i = 0; i < 70; i++) send(0, 1);
        drain_check();

        // Reset mid-plateau.
        load(8, 5, 0, 0);
        for (int i = 0; i < 13; i++) send(0, 1);
        for (int i = 0; i < 8; i++) send(100, 1);
        idle(2);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_output_data", output_data, 0);
        q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset(8, 5, 16, 7);
        wait_flush();
        chk("midrst_cfg_err", cfg_err, 0);
        for (int i = 0; i < 13; i++) send(0, 1);
        for (int i = 0; i < 16; i++) send($urandom_range(16383), 1);
        drain_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
